// File: rtl/mux_scan_nx1.sv
// Registered NCH:1 channel multiplexer with one-shot manual capture and masked round-robin scan.
// Define MUX_SCAN_CONT_EN for continuous scanning, which wraps the sweep until mode drops to 0.
module mux_scan_nx1 #(
   parameter int NCH   = 16,
   parameter int WIDTH = 8,
   parameter int DWELL = 4,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH*WIDTH-1:0]  in_data,
   input  logic [NCH-1:0]        in_mask,
   input  logic                  mode,
   input  logic [SELW-1:0]       sel,
   input  logic                  start,
   output logic [WIDTH-1:0]      out_data,
   output logic [SELW-1:0]       out_ch,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_err,
   output logic                  busy
);

   localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SELW:0]   NCH_LIM  = (SELW + 1)'(NCH);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DWELL = 2'd1,
      S_EMIT  = 2'd2
   } state_t;

   state_t            state_reg,    state_next;
   logic [NCH-1:0]    mask_reg,     mask_next;
   logic [SELW-1:0]   ch_reg,       ch_next;
   logic [CNTW-1:0]   cnt_reg,      cnt_next;
   logic              mode_reg,     mode_next;
   logic [WIDTH-1:0]  out_data_reg, out_data_next;
   logic [SELW-1:0]   out_ch_reg,   out_ch_next;
   logic              out_valid_reg, out_valid_next;
   logic              out_err_reg,  out_err_next;

   logic [WIDTH-1:0]  chan [NCH];
   logic [SELW-1:0]   low_in;
   logic [SELW-1:0]   next_ch;
   logic              next_found;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
   end

   // Priority encoders: lowest set bit of the live mask, and next set bit of the latched mask above ch.
   always_comb begin
      low_in     = '0;
      next_ch    = '0;
      next_found = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (in_mask[i]) begin
            low_in = SELW'(i);
         end
         if (mask_reg[i] && (i > int'(ch_reg))) begin
            next_ch    = SELW'(i);
            next_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      mask_next      = mask_reg;
      ch_next        = ch_reg;
      cnt_next       = cnt_reg;
      mode_next      = mode_reg;
      out_data_next  = out_data_reg;
      out_ch_next    = out_ch_reg;
      out_valid_next = out_valid_reg;
      out_err_next   = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               mode_next = mode;
               if (!mode) begin
                  if ({1'b0, sel} < NCH_LIM) begin
                     out_data_next  = chan[sel];
                     out_ch_next    = sel;
                     out_valid_next = 1'b1;
                     state_next     = S_EMIT;
                  end else begin
                     out_err_next = 1'b1;
                  end
               end else begin
                  mask_next = in_mask;
                  if (in_mask == '0) begin
                     out_err_next = 1'b1;
                  end else begin
                     ch_next    = low_in;
                     cnt_next   = '0;
                     state_next = S_DWELL;
                  end
               end
            end
         end

         S_DWELL: begin
            if (cnt_reg == CNT_LAST) begin
               out_data_next  = chan[ch_reg];
               out_ch_next    = ch_reg;
               out_valid_next = 1'b1;
               state_next     = S_EMIT;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         S_EMIT: begin
            if (out_valid_reg && out_ready) begin
               out_valid_next = 1'b0;
               if (!mode_reg) begin
                  state_next = S_IDLE;
`ifdef MUX_SCAN_CONT_EN
               end else if (!mode) begin
                  state_next = S_IDLE;
               end else if (next_found) begin
                  ch_next    = next_ch;
                  cnt_next   = '0;
                  state_next = S_DWELL;
               end else begin
                  // Wrap: take a fresh copy of the mask for the next pass.
                  mask_next = in_mask;
                  if (in_mask == '0) begin
                     out_err_next = 1'b1;
                     state_next   = S_IDLE;
                  end else begin
                     ch_next    = low_in;
                     cnt_next   = '0;
                     state_next = S_DWELL;
                  end
               end
`else
               end else if (next_found) begin
                  ch_next    = next_ch;
                  cnt_next   = '0;
                  state_next = S_DWELL;
               end else begin
                  state_next = S_IDLE;
               end
`endif
            end
         end

         default: begin
            state_next     = S_IDLE;
            out_valid_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         mask_reg      <= '0;
         ch_reg        <= '0;
         cnt_reg       <= '0;
         mode_reg      <= 1'b0;
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         out_valid_reg <= 1'b0;
         out_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mask_reg      <= mask_next;
         ch_reg        <= ch_next;
         cnt_reg       <= cnt_next;
         mode_reg      <= mode_next;
         out_data_reg  <= out_data_next;
         out_ch_reg    <= out_ch_next;
         out_valid_reg <= out_valid_next;
         out_err_reg   <= out_err_next;
      end
   end

   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;
   assign out_valid = out_valid_reg;
   assign out_err   = out_err_reg;
   assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Scoreboard bench for mux_scan_nx1: stimulus pushes expected samples, a negedge monitor pops and compares.
// A second NCH=12 instance covers the out-of-range manual select.
module tb_mux_scan_nx1;

   localparam int NCH   = 16;
   localparam int WIDTH = 8;
   localparam int SELW  = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_mask;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic                 start;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_err;
   logic                 busy;

   logic [12*WIDTH-1:0]  in_data12;
   logic [11:0]          in_mask12;
   logic [3:0]           sel12;
   logic                 start12;
   logic [WIDTH-1:0]     out_data12;
   logic [3:0]           out_ch12;
   logic                 out_valid12;
   logic                 out_ready12;
   logic                 out_err12;
   logic                 busy12;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SELW-1:0]  ch;
   } sample_t;

   sample_t exp_q [$];

   always #5 clk = ~clk;

   mux_scan_nx1 #(.NCH(NCH), .WIDTH(WIDTH), .DWELL(4)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_mask(in_mask), .mode(mode),
      .sel(sel), .start(start), .out_data(out_data), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err), .busy(busy)
   );

   mux_scan_nx1 #(.NCH(12), .WIDTH(WIDTH), .DWELL(4)) dut12 (
      .clk(clk), .rst(rst), .in_data(in_data12), .in_mask(in_mask12), .mode(mode),
      .sel(sel12), .start(start12), .out_data(out_data12), .out_ch(out_ch12),
      .out_valid(out_valid12), .out_ready(out_ready12), .out_err(out_err12), .busy(busy12)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch);
      sample_t s;
      s.data = 8'hA0 + 8'(ch);
      s.ch   = SELW'(ch);
      exp_q.push_back(s);
   endtask

   // Counts cycles until out_valid, starting at 1 for the cycle after the start edge.
   task automatic wait_valid(input string name, output int n);
      n = 1;
      while (!out_valid && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      chk({name, "_busy_drop"}, 32'(busy), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got ch=%0d data=%0h expected none", out_ch, out_data);
         end else begin
            sample_t e;
            e = exp_q.pop_front();
            $display("sample ch=%0d data=%0h (expected ch=%0d data=%0h)", out_ch, out_data, e.ch, e.data);
            chk("sample_data", 32'(out_data), 32'(e.data));
            chk("sample_ch", 32'(out_ch), 32'(e.ch));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; mode = 1'b0; sel = '0; in_mask = '0; out_ready = 1'b0;
      sel12 = '0; start12 = 1'b0; in_mask12 = '0; out_ready12 = 1'b1;
      for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = 8'hA0 + 8'(k);
      for (int k = 0; k < 12; k++) in_data12[k*WIDTH +: WIDTH] = 8'hB0 + 8'(k);

      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ch", 32'(out_ch), 32'd0);
      chk("rst_err", 32'(out_err), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Manual capture, sel=5
      out_ready = 1'b1; mode = 1'b0; sel = 4'd5; start = 1'b1;
      push(5);
      tick();
      start = 1'b0;
      chk("man_valid", 32'(out_valid), 32'd1);
      chk("man_busy", 32'(busy), 32'd1);
      tick();
      chk("man_done_valid", 32'(out_valid), 32'd0);
      chk("man_done_busy", 32'(busy), 32'd0);

`ifndef MUX_SCAN_CONT_EN
      // Single sweep over channels 0,4,15; mask/mode/sel changes mid-sweep must not matter
      mode = 1'b1; in_mask = 16'h8011; start = 1'b1;
      push(0); push(4); push(15);
      tick();
      start = 1'b0; in_mask = 16'h0002; mode = 1'b0; sel = 4'd9;
      chk("scan_busy", 32'(busy), 32'd1);
      wait_valid("scan_lat", n);
      chk("scan_latency", 32'(n), 32'd5);
      wait_idle("scan");
      chk("scan_queue_empty", 32'(exp_q.size()), 32'd0);
`else
      // Continuous sweep 0,1,0,1,0 then mode drop ends it
      mode = 1'b1; in_mask = 16'h0003; out_ready = 1'b0; start = 1'b1;
      push(0); push(1); push(0); push(1); push(0);
      tick();
      start = 1'b0;
      for (int s = 0; s < 5; s++) begin
         wait_valid("cont_lat", n);
         if (s == 4) mode = 1'b0;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      chk("cont_busy_end", 32'(busy), 32'd0);
      chk("cont_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

      // Backpressure: hold for 6 cycles with ignored start pulses and live data changing
      mode = 1'b0; sel = 4'd3; out_ready = 1'b0; start = 1'b1;
      push(3);
      tick();
      start = 1'b0;
      in_data[3*WIDTH +: WIDTH] = 8'h55;
      for (int i = 0; i < 6; i++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", 32'(out_data), 32'hA3);
         chk("bp_ch", 32'(out_ch), 32'd3);
         chk("bp_err", 32'(out_err), 32'd0);
         sel   = 4'd7;
         start = (i == 1 || i == 3);
         tick();
      end
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_done_valid", 32'(out_valid), 32'd0);
      chk("bp_done_busy", 32'(busy), 32'd0);
      in_data[3*WIDTH +: WIDTH] = 8'hA3;
      tick();
      chk("bp_no_extra", 32'(out_valid), 32'd0);

      // Scan with empty mask
      mode = 1'b1; in_mask = '0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("empty_err", 32'(out_err), 32'd1);
      chk("empty_busy", 32'(busy), 32'd0);
      tick();
      chk("empty_err_pulse", 32'(out_err), 32'd0);
      chk("empty_valid", 32'(out_valid), 32'd0);

      // NCH=12 instance: out-of-range then in-range manual select
      mode = 1'b0; sel12 = 4'd13; start12 = 1'b1;
      tick();
      start12 = 1'b0;
      chk("n12_err", 32'(out_err12), 32'd1);
      chk("n12_valid", 32'(out_valid12), 32'd0);
      chk("n12_busy", 32'(busy12), 32'd0);
      tick();
      chk("n12_err_pulse", 32'(out_err12), 32'd0);
      sel12 = 4'd11; start12 = 1'b1;
      tick();
      start12 = 1'b0;
      chk("n12_ok_valid", 32'(out_valid12), 32'd1);
      chk("n12_ok_data", 32'(out_data12), 32'hBB);
      chk("n12_ok_ch", 32'(out_ch12), 32'd11);
      chk("n12_ok_err", 32'(out_err12), 32'd0);
      tick();

      // Asynchronous reset during dwell on channel 4
      mode = 1'b1; in_mask = 16'h0010; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_data", 32'(out_data), 32'd0);
      chk("arst_ch", 32'(out_ch), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd0);

      mode = 1'b1; in_mask = 16'h0010; start = 1'b1;
      push(4);
      tick();
      start = 1'b0;
      wait_valid("rescan_lat", n);
      chk("rescan_latency", 32'(n), 32'd5);
      wait_idle("rescan");
      tick();
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_scan_nx1.md
Name: mux_scan_nx1

Overview:
- Parametrised, registered N:1 multiplexer that generalises the fixed 16x1 gate-level mux.
- NCH channels of WIDTH bits each.
- Two modes:
  - Manual: one-shot capture of the selected channel.
  - Scan: round-robin sweep over a channel mask, dwelling DWELL cycles per channel.
- Samples are emitted on a valid/ready output port. The block feeds sequencing and sampling logic downstream of the combinational mux tree.

Parameters:
- NCH, 16, number of input channels (>=2).
- WIDTH, 8, bits per channel.
- DWELL, 4, cycles spent on a channel before sampling in scan mode (>=1).
- SELW, $clog2(NCH), select and channel-index width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_mask  input  NCH  scan enable per channel; bit k = channel k
- mode  input  1  0 = manual, 1 = scan; sampled on accepted start
- sel  input  SELW  manual channel index; sampled on accepted start
- start  input  1  request; accepted only when busy=0
- out_data  output  WIDTH  captured sample
- out_ch  output  SELW  channel index of out_data
- out_valid  output  1  sample available
- out_ready  input  1  downstream accepts sample
- out_err  output  1  one-cycle pulse on a rejected request
- busy  output  1  state != IDLE

Behaviour:
- Reset:
  - rst=1 asynchronously forces state IDLE and clears the captured mask (mask_q), the current channel (ch) and the dwell counter (cnt).
  - out_data, out_ch, out_valid, out_err and busy all go to 0.
  - Reset mid-sweep or mid-handshake discards the pending sample; no output is held over.
- Channel mapping: sel=k selects channel k, i.e. in_data[k*WIDTH +: WIDTH], for every k. No inverted or bit-reversed ordering.
- FSM states: IDLE, DWELL, EMIT.
- IDLE, start=1 and mode=0 (manual):
  - If sel < NCH: next edge sets out_data = slice[sel], out_ch = sel, out_valid = 1, goes to EMIT. Latency is 1 cycle.
  - If sel >= NCH: out_err = 1 for one cycle, stays IDLE, out_valid stays 0.
- IDLE, start=1 and mode=1 (scan):
  - in_mask is captured into mask_q.
  - If in_mask == 0: out_err pulses and the FSM stays IDLE.
  - Otherwise: ch = lowest set bit of in_mask, cnt = 0, goes to DWELL.
- DWELL:
  - cnt increments each cycle.
  - At cnt == DWELL-1: the next edge captures slice[ch] into out_data, sets out_ch = ch and out_valid = 1, goes to EMIT.
  - The first sample's out_valid rises DWELL+1 cycles after the start cycle.
- EMIT:
  - out_valid, out_data and out_ch are held stable until out_valid and out_ready are both 1 on an edge.
  - On that edge: out_valid = 0.
  - Manual: goes to IDLE.
  - Scan: ch = next set bit of mask_q strictly above ch, cnt = 0, goes to DWELL. If no higher bit is set, the sweep is complete and the FSM goes to IDLE.
- Handshake: out_ready may be asserted before out_valid and has no effect outside EMIT. No combinational path from out_ready to out_valid.
- Input changes while busy:
  - start is ignored while busy=1; no out_err is raised.
  - in_mask, mode and sel changes mid-sweep have no effect (mask_q and mode are latched).
- in_data is live: the sample is taken on the capture edge, not at start.
- busy = 1 in DWELL and EMIT, including the cycle out_valid first rises.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined (continuous scan):
  - When the last set bit of mask_q is consumed, the sweep wraps to the lowest set bit and continues.
  - The sweep ends, returning to IDLE after the current handshake completes, only when mode is 0 at that handshake edge.
  - in_mask is re-captured into mask_q at each wrap.
  - If the re-captured mask is 0: out_err pulses and the FSM goes to IDLE.
- Undefined (single sweep): one pass per start, as described under Behaviour.
- Manual-mode behaviour is identical in both builds.

Test Plan:
- Manual: in_data slice k = 8'hA0+k, start with mode=0, sel=5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_ch=5; then IDLE, busy=0.
- Scan: in_mask=16'h8011, out_ready=1, DWELL=4, start -> samples for channels 0, 4, 15 in order; first out_valid 5 cycles after start; busy drops after channel 15.
- Backpressure: manual sel=3 with out_ready=0 for 6 cycles -> out_valid and out_data=8'hA3 held stable for 6 cycles; start pulses during the hold are ignored; handshake completes on the first out_ready=1 cycle.
- Errors:
  - Scan start with in_mask=0 -> out_err pulses 1 cycle, busy stays 0.
  - NCH=12 build, manual sel=13 -> out_err pulses, no out_valid.
- Reset mid-sweep: assert rst during DWELL on channel 4 -> out_valid, busy and out_data all 0 immediately (asynchronous); after release, a new start behaves as from power-up.
- MUX_SCAN_CONT_EN: in_mask=16'h0003, mode held at 1 -> channel sequence 0,1,0,1,...; drop mode to 0 during a sample -> that handshake completes, then IDLE.
